// File: rtl/counter_sched_pkg.sv
// Shared types for the round-robin counter scheduler: FSM state encoding.
package counter_sched_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure, an empty req yields pick = 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one down-counter: grant at t+1, done pulse at t+2+len, next grant t+4+len.
// Requests hold until done; optional abort of the granted run when COUNTER_SCHED_ABORT_EN is defined.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic [N_REQ-1:0]       abort,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt, win, win_nxt, win_inc, pick_idx;
  logic [N_REQ-1:0]  pick, gnt_nxt, done_nxt;
  logic [WIDTH-1:0]  count_nxt;
  logic [WIDTH-1:0]  len_arr [N_REQ];
  logic              abort_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_len
    assign len_arr[i] = len[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_hit = abort[win];
`else
  assign abort_hit = 1'b0;
`endif

  assign win_inc = (win == IDX_W'(N_REQ-1)) ? '0 : win + 1'b1;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    count_nxt = count;
    ptr_nxt   = ptr;
    win_nxt   = win;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = RUN;
          gnt_nxt   = pick;
          count_nxt = len_arr[pick_idx];
          win_nxt   = pick_idx;
        end
      end
      RUN: begin
        if (count != '0) begin
          // Completion takes priority over abort once the counter has reached zero
          if (abort_hit) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            count_nxt = '0;
            ptr_nxt   = win_inc;
          end else begin
            count_nxt = count - 1'b1;
          end
        end else begin
          state_nxt     = DONE;
          gnt_nxt       = '0;
          done_nxt[win] = 1'b1;
          ptr_nxt       = win_inc;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      ptr   <= '0;
      win   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      count <= count_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
    end
  end

endmodule
